// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: fetches each covering entity's sprite row into per-slot line
// buffers during h-blank, then emits a registered pixel-on/slot lookup in active video.
module sprite_line_fetcher #(
    parameter int N_SLOTS  = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic [17*N_SLOTS-1:0] entities,
    output logic [3:0]           rom_sprite_id,
    output logic [1:0]           rom_orientation,
    output logic [2:0]           rom_line_index,
    input  logic [7:0]           rom_data,
    output logic                 pixel_on,
    output logic [2:0]           pixel_slot,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    localparam logic [2:0] LAST = 3'(N_SLOTS - 1);
    state_t state, nxt_state;
    logic [2:0] idx, nxt_idx, win;
    logic [16:0] ent [8];
    logic [16:0] e;
    logic [10:0] nl, top, dy;
    logic hit_e, m_q;
    logic [7:0] valid, lit;
    logic [7:0] line_buf [8];
    logic [5:0] col_q [8];
    // slots beyond N_SLOTS read as permanently empty and never light
    for (genvar g = 0; g < 8; g++) begin : g_slot
        logic [10:0] base, off;
        if (g < N_SLOTS) begin : g_e
            assign ent[g] = entities[g*17 +: 17];
        end else begin : g_n
            assign ent[g] = 17'h07800;
        end
        assign base = {1'b0, col_q[g], 4'b0};
        assign off = {1'b0, hpos} - base;
        assign lit[g] = valid[g] && {1'b0, hpos} >= base && off < 11'd16 && !line_buf[g][off[3:1]];
    end
    assign busy = state != IDLE;
    assign e = ent[nxt_idx];
    assign nl = (vpos == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, vpos} + 11'd1;
    assign top = {2'b0, e[10:6], 4'b0};
    assign dy = nl - top;
    assign hit_e = nl < 11'(V_ACTIVE) && e[14:11] != 4'hF && nl >= top && dy < 11'd16;
    always_comb begin
        nxt_state = state;
        nxt_idx = idx;
        unique case (state)
            IDLE: begin
                nxt_state = (hpos == 10'(H_ACTIVE)) ? ISSUE : IDLE;
                nxt_idx = (hpos == 10'(H_ACTIVE)) ? 3'd0 : idx;
            end
            ISSUE: nxt_state = CAPTURE;
            CAPTURE: begin
                nxt_state = (idx == LAST) ? IDLE : ISSUE;
                nxt_idx = (idx == LAST) ? idx : idx + 3'd1;
            end
            default: nxt_state = IDLE;
        endcase
    end
    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (lit[i]) win = 3'(i);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= 3'd0;
            rom_sprite_id <= 4'hF;
            rom_orientation <= 2'd0;
            rom_line_index <= 3'd0;
            m_q <= 1'b0;
            valid <= 8'd0;
            line_buf <= '{default: 8'hFF};
            col_q <= '{default: 6'd0};
            pixel_on <= 1'b0;
            pixel_slot <= 3'd0;
        end else begin
            state <= nxt_state;
            idx <= nxt_idx;
            rom_sprite_id <= (nxt_state == ISSUE && hit_e) ? e[14:11] : 4'hF;
            rom_orientation <= (nxt_state == ISSUE && hit_e) ? e[16:15] : 2'd0;
            rom_line_index <= (nxt_state == ISSUE && hit_e) ? dy[3:1] : 3'd0;
            if (nxt_state == ISSUE) begin
                col_q[nxt_idx] <= e[5:0];
                m_q <= hit_e;
            end
            if (state == CAPTURE) begin
                line_buf[idx] <= rom_data;
                valid[idx] <= m_q;
            end
            pixel_on <= |lit && hpos < 10'(H_ACTIVE) && vpos < 10'(V_ACTIVE);
            pixel_slot <= (|lit && hpos < 10'(H_ACTIVE) && vpos < 10'(V_ACTIVE)) ? win : 3'd0;
        end
    end
endmodule
